// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_pkg;

  localparam int BIN_W_DEF      = 16;
  localparam int NUM_DIGITS_DEF = 5;

  typedef logic [3:0] bcd_digit_t;

  // A digit above this value must be corrected before the next left shift.
  localparam bcd_digit_t ADD3_THRESH = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit greater than 4.
// Latency: combinational.
// Backpressure: none.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t d_in,
  output bcd_digit_t d_out
);

  assign d_out = (d_in > ADD3_THRESH) ? bcd_digit_t'(d_in + 4'd3) : d_in;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Latency: start accepted at edge 0, result and one-cycle done after edge BIN_W.
// Backpressure: start is accepted only while ready; requests while busy or done are dropped.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W      = BIN_W_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic [3:0]       tenThousands
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int CHN_W = 4 * NUM_DIGITS;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BIN_W-1:0]              sr_q, sr_d;
  bcd_digit_t [NUM_DIGITS-1:0]   work_q, work_d;
  bcd_digit_t [NUM_DIGITS-1:0]   dig_q, dig_d;
  bcd_digit_t [NUM_DIGITS-1:0]   corr;
  logic [CHN_W-1:0]              corr_flat;

  // Per-digit correction of the working digits ahead of each shift.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d_in  (work_q[i]),
      .d_out (corr[i])
    );
  end

  assign corr_flat = corr;

  // Next-state, shift datapath and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    work_d  = work_q;
    dig_d   = dig_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin_in;
          work_d  = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Digit chain and operand rotate as one register; the bit leaving the
        // top digit is always 0 when NUM_DIGITS covers the operand range, so it
        // simply back-fills the operand's vacated LSB.
        work_d = {corr_flat[CHN_W-2:0], sr_q[BIN_W-1]};
        sr_d   = {sr_q[BIN_W-2:0], corr_flat[CHN_W-1]};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          dig_d   = work_d;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      work_q  <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      work_q  <= work_d;
      dig_q   <= dig_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign busy         = (state_q == SHIFT);
  assign done         = (state_q == DONE);
  assign ones         = dig_q[0];
  assign tens         = dig_q[1];
  assign hundreds     = dig_q[2];
  assign thousands    = dig_q[3];
  assign tenThousands = dig_q[4];

endmodule

// File: doc/bcd_seq_converter.md
BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 Parameter BIN_W, default 16: binary input width.
REQ-002 Parameter NUM_DIGITS, default 5: BCD output digits; the default pair BIN_W=16, NUM_DIGITS=5 is the only configuration that needs to be verified.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: conversion request, sampled on clk rising edge.
REQ-006 bin_in  input  BIN_W: binary operand, captured when start is accepted.
REQ-007 ready  output  1: high when a start will be accepted.
REQ-008 busy  output  1: high while a conversion is in progress.
REQ-009 done  output  1: one-cycle pulse when a new result is on the outputs.
REQ-010 ones, tens, hundreds, thousands, tenThousands  output  4 each: registered BCD result digits.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE; ready = (state==IDLE); busy = (state==SHIFT).
REQ-012 IDLE with start=1 at an edge: capture bin_in into the shift register, clear the working digits, load the bit counter with BIN_W-1, go to SHIFT.
REQ-013 IDLE with start=0: remain in IDLE; outputs hold.
REQ-014 SHIFT, each edge: add 3 to every working digit >4, then shift the digit chain left one bit; shift the MSB of the shift register into ones[0].
REQ-015 SHIFT: decrement the counter each edge; on the edge where the counter is 0, load the output digit registers from the corrected and shifted working digits, then go to DONE.
REQ-016 Latency: start accepted at edge 0 gives shifts on edges 1..16 and done=1 during the cycle after edge 16.
REQ-017 DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
REQ-018 start while in SHIFT or DONE: ignored, with no queueing, and bin_in changes have no effect.
REQ-019 Output digits change only on the completion edge and hold the last result between conversions.
REQ-020 Every output digit is at most 9 for every bin_in; maximum input 65535 gives tenThousands=6.
REQ-021 Back-to-back conversions: start held high continuously gives a new acceptance every 18 cycles (IDLE, 16×SHIFT, DONE).

Reset
REQ-022 rst_n low: immediately go to IDLE; ready=1, busy=0, done=0, all digits 0, counter and shift register 0.
REQ-023 Reset during SHIFT aborts the conversion; no done pulse, and outputs go to 0.
REQ-024 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-025 Shared package bcd_pkg holds BIN_W/NUM_DIGITS defaults, the state enum (IDLE/SHIFT/DONE), the constant ADD3_THRESH=4 and the BCD digit type (4 bits).
REQ-026 Sub-module bcd_add3 (combinational: 4-bit in, 4-bit out, +3 if >4) is instantiated once per digit.
REQ-027 Counter width = $clog2(BIN_W); there are no combinational paths from inputs to outputs.

Verification
REQ-028 Reset then start with bin_in=16'd0 -> done at cycle 17 after acceptance; digits 0,0,0,0,0.
REQ-029 bin_in=16'd65535 -> tenThousands..ones = 6,5,5,3,5; done high exactly 1 cycle.
REQ-030 bin_in=16'd12345, then start pulsed mid-SHIFT with bin_in=16'd9999 -> result 1,2,3,4,5; second start ignored; ready=0 throughout.
REQ-031 start held high with bin_in alternating 9999 / 40960 per acceptance -> results 0,9,9,9,9 then 4,0,9,6,0; accepts 18 cycles apart.
REQ-032 rst_n pulsed low at shift 8 of bin_in=16'd54321 -> digits 0 immediately, no done; next start with 54321 -> 5,4,3,2,1.
REQ-033 Random 10k values against a reference divide/mod model; outputs are stable between done pulses.
